// File: rtl/choice_pkg.sv
// choice_pkg: shared types and helpers for the choice predictor.
//   choice_state_t : 2-bit saturating chooser state (L1 < L0 < G0 < G1)
//   ctrl_state_t   : table controller phase (INIT sweep, then RUN)
//   choice_next()  : saturating one-step move, dir=1 toward G1
//   choice_sel()   : 1 selects the global prediction
// Also used by the scalar choice predictor.
package choice_pkg;

    typedef enum logic [1:0] {
        L1 = 2'd0,
        L0 = 2'd1,
        G0 = 2'd2,
        G1 = 2'd3
    } choice_state_t;

    typedef enum logic {
        CTRL_INIT = 1'b0,
        CTRL_RUN  = 1'b1
    } ctrl_state_t;

    localparam choice_state_t CHOICE_INIT = L0;

    function automatic choice_state_t choice_next(input choice_state_t state, input logic dir);
        choice_state_t nxt;
        case (state)
            L1:      nxt = dir ? L0 : L1;
            L0:      nxt = dir ? G0 : L1;
            G0:      nxt = dir ? G1 : L0;
            G1:      nxt = dir ? G1 : G0;
            default: nxt = CHOICE_INIT;
        endcase
        return nxt;
    endfunction

    // G0 and G1 are exactly the encodings with the upper bit set
    function automatic logic choice_sel(input choice_state_t state);
        return state[1];
    endfunction

endpackage

// File: rtl/choice_upd_fifo.sv
// choice_upd_fifo: synchronous FIFO holding pending chooser updates.
//   clock, reset   : clock and synchronous active-high reset (flushes contents)
//   push_i/data_i  : enqueue request; ignored when full
//   pop_i          : dequeue request; ignored when empty
//   pop_data_o     : current head entry (valid when not empty)
//   count_o        : number of queued entries, 0..FIFO_DEPTH
//   full_o/empty_o : occupancy flags
module choice_upd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 13
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full_o     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o    = (count_q == {CNT_W{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_s     = push_i && !full_o;
    assign pop_s      = pop_i && !empty_o;

    // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates their use
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/choice_table_ctrl.sv
// choice_table_ctrl: chooser table controller for the tournament predictor.
//   clock, reset        : clock and synchronous active-high reset
//   lookup_*            : fetch-time lookup; pred_valid/pred_choice one cycle later
//                         (pred_choice 0 = local, 1 = global)
//   upd_*               : retire-time outcome; only disagreeing outcomes are queued
//   init_done           : table sweep finished, controller in RUN
//   fifo_count          : number of queued updates
// The table has one access per cycle: the INIT sweep, a lookup, or a queued
// update drain (read-modify-write). A full queue takes priority over lookups.
module choice_table_ctrl
    import choice_pkg::*;
#(
    parameter int INDEX_W    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        lookup_valid,
    input  logic [INDEX_W-1:0]          lookup_index,
    output logic                        lookup_ready,
    output logic                        pred_valid,
    output logic                        pred_choice,
    input  logic                        upd_valid,
    input  logic [INDEX_W-1:0]          upd_index,
    input  logic                        upd_local_correct,
    input  logic                        upd_global_correct,
    output logic                        upd_ready,
    output logic                        init_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int ENTRIES = 2**INDEX_W;

    ctrl_state_t        state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_choice_q, pred_choice_d;
    logic [1:0]         table_q [ENTRIES];

    logic               run_s, fifo_full_s, fifo_empty_s;
    logic               lookup_acc_s, drain_s, push_s;
    logic [INDEX_W:0]   head_s;
    logic [INDEX_W-1:0] head_idx_s, rd_addr_s, tbl_waddr_s;
    logic               head_dir_s, tbl_we_s;
    choice_state_t      rd_state_s, tbl_wdata_s;

    choice_upd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (INDEX_W + 1)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i ({upd_index, upd_global_correct}),
        .pop_i       (drain_s),
        .pop_data_o  (head_s),
        .count_o     (fifo_count),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign run_s        = (state_q == CTRL_RUN);
    assign lookup_ready = run_s && !fifo_full_s;
    assign upd_ready    = run_s && !fifo_full_s;
    assign init_done    = run_s;
    assign pred_valid   = pred_valid_q;
    assign pred_choice  = pred_choice_q;

    assign head_idx_s   = head_s[INDEX_W:1];
    assign head_dir_s   = head_s[0];
    assign lookup_acc_s = lookup_valid && lookup_ready;
    // Drain when full (forced) or when the port is otherwise idle
    assign drain_s      = run_s && !fifo_empty_s && (fifo_full_s || !lookup_valid);
    // Agreeing outcomes carry no information for the chooser
    assign push_s       = upd_valid && upd_ready && (upd_local_correct != upd_global_correct);

    // Single shared read address: drain and lookup never coincide
    assign rd_addr_s    = drain_s ? head_idx_s : lookup_index;
    assign rd_state_s   = choice_state_t'(table_q[rd_addr_s]);

    // Controller next-state, table write port and lookup response
    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        tbl_we_s      = 1'b0;
        tbl_waddr_s   = init_idx_q;
        tbl_wdata_s   = CHOICE_INIT;
        pred_valid_d  = lookup_acc_s;
        pred_choice_d = 1'b0;
        if (state_q == CTRL_INIT) begin
            tbl_we_s   = 1'b1;
            init_idx_d = init_idx_q + {{(INDEX_W-1){1'b0}}, 1'b1};
            if (&init_idx_q) begin
                state_d = CTRL_RUN;
            end else begin
                state_d = CTRL_INIT;
            end
        end else if (drain_s) begin
            tbl_we_s    = 1'b1;
            tbl_waddr_s = head_idx_s;
            tbl_wdata_s = choice_next(rd_state_s, head_dir_s);
        end else begin
            tbl_we_s = 1'b0;
        end
        if (lookup_acc_s) begin
            pred_choice_d = choice_sel(rd_state_s);
        end else begin
            pred_choice_d = 1'b0;
        end
    end

    // Controller FSM and registered lookup response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CTRL_INIT;
            init_idx_q    <= {INDEX_W{1'b0}};
            pred_valid_q  <= 1'b0;
            pred_choice_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            pred_valid_q  <= pred_valid_d;
            pred_choice_q <= pred_choice_d;
        end
    end

    // Table storage, written by the INIT sweep or a drain
    always_ff @(posedge clock) begin
        if (!reset && tbl_we_s) begin
            table_q[tbl_waddr_s] <= tbl_wdata_s;
        end
    end

endmodule
